// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory distribution path:
// default word width and the channel select encoding also used by the 2:1 select mux.
package dmem_pkg;

  localparam int DMEM_WIDTH = 32;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/dmem_demux_1to2_if.sv
// Handshake bundle of the 1-to-2 demux: one select-tagged input stream and two output streams.
// slave is the demux view; master is the source/consumer side.
interface dmem_demux_1to2_if
  import dmem_pkg::*;
#(
  parameter int WIDTH = DMEM_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;

  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data
  );

  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data
  );

endinterface

// File: rtl/dmem_chan_fifo.sv
// Per-channel FIFO for the demux: DEPTH entries, registered pointers/occupancy,
// head word presented directly from storage, and a wrapping count of popped words.
module dmem_chan_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNT_W-1:0] pop_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
  logic             push_s;
  logic             pop_s;

  assign full_o    = (count_q == OCC_W'(DEPTH));
  assign valid_o   = (count_q != {OCC_W{1'b0}});
  assign dout_o    = mem_q[rd_ptr_q];
  assign pop_cnt_o = pop_cnt_q;

  // Next-state for pointers, occupancy and pop counter; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    push_s    = push_i && !full_o;
    pop_s     = valid_o && ready_i;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pop_cnt_d = pop_cnt_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      pop_cnt_d = pop_cnt_q + CNT_W'(1);
    end else begin
      rd_ptr_d  = rd_ptr_q;
      pop_cnt_d = pop_cnt_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State and storage registers; reset discards buffered words and clears storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {OCC_W{1'b0}};
      pop_cnt_q <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pop_cnt_q <= pop_cnt_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= din_i;
      end
    end
  end

endmodule

// File: rtl/dmem_demux_1to2.sv
// Buffered 1-to-2 demux: steers each input word to channel A (sel=1) or B (sel=0),
// each channel buffered by its own FIFO so a stalled consumer never blocks the other.
module dmem_demux_1to2
  import dmem_pkg::*;
#(
  parameter int WIDTH = DMEM_WIDTH,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  dmem_demux_1to2_if.slave        bus,
  output logic [CNT_W-1:0]        cnt_a,
  output logic [CNT_W-1:0]        cnt_b
);

  logic a_full_s;
  logic b_full_s;
  logic in_ready_s;
  logic push_a_s;
  logic push_b_s;

  // Ready depends only on the selected channel's occupancy, never on the consumer ready inputs.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else if (bus.in_sel == SEL_A) begin
      in_ready_s = !a_full_s;
    end else begin
      in_ready_s = !b_full_s;
    end
    push_a_s = bus.in_valid && in_ready_s && (bus.in_sel == SEL_A);
    push_b_s = bus.in_valid && in_ready_s && (bus.in_sel == SEL_B);
  end

  assign bus.in_ready = in_ready_s;

  dmem_chan_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo_a (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push_a_s),
    .din_i    (bus.in_data),
    .full_o   (a_full_s),
    .valid_o  (bus.a_valid),
    .ready_i  (bus.a_ready),
    .dout_o   (bus.a_data),
    .pop_cnt_o(cnt_a)
  );

  dmem_chan_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo_b (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push_b_s),
    .din_i    (bus.in_data),
    .full_o   (b_full_s),
    .valid_o  (bus.b_valid),
    .ready_i  (bus.b_ready),
    .dout_o   (bus.b_data),
    .pop_cnt_o(cnt_b)
  );

endmodule

// File: tb/tb_dmem_demux_1to2.sv
// Directed self-checking bench for dmem_demux_1to2 (DEPTH=2, CNT_W=4 so the pop counter wrap is reachable).
module tb_dmem_demux_1to2;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] exp_cnt_a;
  logic [CNT_W-1:0] exp_cnt_b;
  int               tests_run;
  int               failed;

  dmem_demux_1to2_if #(.WIDTH(WIDTH)) bus ();

  dmem_demux_1to2 #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .cnt_a(cnt_a),
    .cnt_b(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel = 1'b1;
    bus.in_data = 32'hAAAA_5555;
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL rst_in_ready cyc%0d: got %b want 0", i, bus.in_ready); end
      tests_run++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin failed++; $display("FAIL rst_valid cyc%0d: got a=%b b=%b want 0", i, bus.a_valid, bus.b_valid); end
      tests_run++; if (cnt_a !== 4'd0 || cnt_b !== 4'd0) begin failed++; $display("FAIL rst_cnt cyc%0d: got a=%0d b=%0d want 0", i, cnt_a, cnt_b); end
    end
    tests_run++; if (bus.a_data !== 32'h0 || bus.b_data !== 32'h0) begin failed++; $display("FAIL rst_data: got a=%h b=%h want 0", bus.a_data, bus.b_data); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    tests_run++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); end
    tick();
    tests_run++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin failed++; $display("FAIL post_rst_valid: got a=%b b=%b want 0", bus.a_valid, bus.b_valid); end
    exp_cnt_a = 4'd0;
    exp_cnt_b = 4'd0;
  endtask

  task automatic test_routing();
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel = 1'b1;
    bus.in_data = 32'hDEAD_BEEF;
    #1;
    tests_run++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL route_ready_a: got %b want 1", bus.in_ready); end
    tick();
    bus.in_sel = 1'b0;
    bus.in_data = 32'h1234_5678;
    tests_run++; if (bus.a_valid !== 1'b1 || bus.a_data !== 32'hDEAD_BEEF) begin failed++; $display("FAIL route_a: got v=%b d=%h want 1 deadbeef", bus.a_valid, bus.a_data); end
    tests_run++; if (bus.b_valid !== 1'b0) begin failed++; $display("FAIL route_b_empty: got %b want 0", bus.b_valid); end
    tick();
    bus.in_valid = 1'b0;
    exp_cnt_a = exp_cnt_a + 4'd1;
    tests_run++; if (bus.b_valid !== 1'b1 || bus.b_data !== 32'h1234_5678) begin failed++; $display("FAIL route_b: got v=%b d=%h want 1 12345678", bus.b_valid, bus.b_data); end
    tests_run++; if (bus.a_valid !== 1'b0 || cnt_a !== exp_cnt_a) begin failed++; $display("FAIL route_a_pop: got v=%b cnt=%0d want 0 %0d", bus.a_valid, cnt_a, exp_cnt_a); end
    tick();
    exp_cnt_b = exp_cnt_b + 4'd1;
    tests_run++; if (bus.b_valid !== 1'b0 || cnt_b !== exp_cnt_b) begin failed++; $display("FAIL route_b_pop: got v=%b cnt=%0d want 0 %0d", bus.b_valid, cnt_b, exp_cnt_b); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    w[0] = 32'hA000_0001;
    w[1] = 32'hA000_0002;
    w[2] = 32'hA000_0003;
    bus.a_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_data = w[i];
      #1;
      tests_run++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL bp_accept w%0d: got %b want 1", i + 1, bus.in_ready); end
      tick();
    end
    bus.in_data = w[2];
    #1;
    tests_run++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL bp_full: got %b want 0", bus.in_ready); end
    tick();
    tests_run++; if (bus.in_ready !== 1'b0 || bus.a_data !== w[0]) begin failed++; $display("FAIL bp_hold: got rdy=%b d=%h want 0 %h", bus.in_ready, bus.a_data, w[0]); end
    bus.a_ready = 1'b1;
    #1;
    tests_run++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL bp_no_bypass: got %b want 0", bus.in_ready); end
    tick();
    tests_run++; if (bus.in_ready !== 1'b1 || bus.a_data !== w[1]) begin failed++; $display("FAIL bp_after_pop1: got rdy=%b d=%h want 1 %h", bus.in_ready, bus.a_data, w[1]); end
    tick();
    bus.in_valid = 1'b0;
    tests_run++; if (bus.a_valid !== 1'b1 || bus.a_data !== w[2]) begin failed++; $display("FAIL bp_w3: got v=%b d=%h want 1 %h", bus.a_valid, bus.a_data, w[2]); end
    tick();
    exp_cnt_a = exp_cnt_a + 4'd3;
    tests_run++; if (bus.a_valid !== 1'b0 || cnt_a !== exp_cnt_a) begin failed++; $display("FAIL bp_drain: got v=%b cnt=%0d want 0 %0d", bus.a_valid, cnt_a, exp_cnt_a); end
  endtask

  task automatic test_isolation();
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel = 1'b1;
    bus.in_data = 32'hCAFE_0001;
    tick();
    bus.in_data = 32'hCAFE_0002;
    tick();
    bus.in_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 32'hB0B0_0000 + i;
      #1;
      tests_run++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL iso_ready w%0d: got %b want 1", i, bus.in_ready); end
      tick();
      tests_run++; if (bus.b_valid !== 1'b1 || bus.b_data !== 32'hB0B0_0000 + i) begin failed++; $display("FAIL iso_b w%0d: got v=%b d=%h want 1 %h", i, bus.b_valid, bus.b_data, 32'hB0B0_0000 + i); end
    end
    bus.in_valid = 1'b0;
    bus.in_sel = 1'b1;
    tick();
    exp_cnt_b = exp_cnt_b + 4'd4;
    tests_run++; if (bus.b_valid !== 1'b0 || cnt_b !== exp_cnt_b) begin failed++; $display("FAIL iso_b_drain: got v=%b cnt=%0d want 0 %0d", bus.b_valid, cnt_b, exp_cnt_b); end
    tests_run++; if (bus.a_valid !== 1'b1 || bus.a_data !== 32'hCAFE_0001 || bus.in_ready !== 1'b0 || cnt_a !== exp_cnt_a) begin failed++; $display("FAIL iso_a_held: got v=%b d=%h rdy=%b cnt=%0d", bus.a_valid, bus.a_data, bus.in_ready, cnt_a); end
    bus.a_ready = 1'b1;
    tick();
    tests_run++; if (bus.a_valid !== 1'b1 || bus.a_data !== 32'hCAFE_0002) begin failed++; $display("FAIL iso_a_second: got v=%b d=%h want 1 cafe0002", bus.a_valid, bus.a_data); end
    tick();
    exp_cnt_a = exp_cnt_a + 4'd2;
    tests_run++; if (bus.a_valid !== 1'b0 || cnt_a !== exp_cnt_a) begin failed++; $display("FAIL iso_a_drain: got v=%b cnt=%0d want 0 %0d", bus.a_valid, cnt_a, exp_cnt_a); end
  endtask

  task automatic test_stream_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt_a = 4'd0;
    exp_cnt_b = 4'd0;
    bus.b_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.in_data = 32'h5000_0000 + i;
      #1;
      tests_run++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL stream_ready w%0d: got %b want 1", i, bus.in_ready); end
      tick();
      if (i > 0) exp_cnt_b = exp_cnt_b + 4'd1;
      tests_run++; if (bus.b_data !== 32'h5000_0000 + i || cnt_b !== exp_cnt_b) begin failed++; $display("FAIL stream w%0d: got d=%h cnt=%0d want %h %0d", i, bus.b_data, cnt_b, 32'h5000_0000 + i, exp_cnt_b); end
    end
    bus.in_valid = 1'b0;
    tick();
    exp_cnt_b = exp_cnt_b + 4'd1;
    tests_run++; if (cnt_b !== 4'd1 || cnt_b !== exp_cnt_b || bus.b_valid !== 1'b0) begin failed++; $display("FAIL stream_wrap_end: got cnt=%0d v=%b want 1 0", cnt_b, bus.b_valid); end
  endtask

  task automatic test_mid_reset();
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_sel = (i < 2) ? 1'b1 : 1'b0;
      bus.in_data = 32'hEEEE_0000 + i;
      tick();
    end
    bus.in_sel = 1'b1;
    #1;
    tests_run++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL mid_a_full: got %b want 0", bus.in_ready); end
    bus.in_sel = 1'b0;
    #1;
    tests_run++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL mid_b_full: got %b want 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin failed++; $display("FAIL mid_valid: got a=%b b=%b want 0", bus.a_valid, bus.b_valid); end
    tests_run++; if (cnt_a !== 4'd0 || cnt_b !== 4'd0) begin failed++; $display("FAIL mid_cnt: got a=%0d b=%0d want 0", cnt_a, cnt_b); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0 || cnt_a !== 4'd0 || cnt_b !== 4'd0) begin failed++; $display("FAIL mid_no_delivery cyc%0d: got av=%b bv=%b ca=%0d cb=%0d", i, bus.a_valid, bus.b_valid, cnt_a, cnt_b); end
    end
  endtask

  initial begin
    tests_run = 0;
    failed = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sel = 1'b0;
    bus.in_data = 32'h0;
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    exp_cnt_a = 4'd0;
    exp_cnt_b = 4'd0;
    test_reset();
    test_routing();
    test_backpressure();
    test_isolation();
    test_stream_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
